// File: rtl/csa_pipe_if.sv
// csa_pipe_if: operand and result handshake bundle for csa_pipe.
// The producer/consumer side uses master; the adder itself uses slave.
interface csa_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, a, b, sub, cin, out_ready,
    input  in_ready, out_valid, sum, cout, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, sub, cin, out_ready,
    output in_ready, out_valid, sum, cout, overflow, zero
  );
endinterface

// File: rtl/csa_pipe.sv
// csa_pipe: pipelined carry-select adder/subtractor, one BLOCK-bit segment per stage.
// Segment k is resolved in stage k by choosing between two precomputed sums with the carry held by stage k-1.
module csa_pipe #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 16
) (
  input logic       clock,
  input logic       reset,
  csa_pipe_if.slave bus
);
  localparam int NSEG = WIDTH / BLOCK;

  if (BLOCK < 1 || WIDTH < BLOCK || (WIDTH % BLOCK) != 0) begin : g_bad_cfg
    $error("csa_pipe: WIDTH must be a non-zero multiple of BLOCK");
  end

  logic [NSEG-1:0]  vld_q;
  logic [WIDTH-1:0] a_q   [NSEG];
  logic [WIDTH-1:0] b_q   [NSEG];
  logic [WIDTH-1:0] res_q [NSEG];
  logic             c_q   [NSEG];
  logic             cm_q  [NSEG];

  logic [NSEG-1:0]  load;
  logic [NSEG-1:0]  src_v;
  logic [WIDTH-1:0] src_a   [NSEG];
  logic [WIDTH-1:0] src_b   [NSEG];
  logic [WIDTH-1:0] src_res [NSEG];
  logic             src_c   [NSEG];
  logic [WIDTH-1:0] nxt_res [NSEG];
  logic             nxt_c   [NSEG];
  logic             nxt_cm  [NSEG];

  // Stage 0 is fed from the bus with B already conditioned for subtraction; later stages from their predecessor.
  always_comb begin
    src_v      = '0;
    src_v[0]   = bus.in_valid;
    src_a[0]   = bus.a;
    src_b[0]   = bus.b ^ {WIDTH{bus.sub}};
    src_res[0] = '0;
    src_c[0]   = bus.sub | bus.cin;
    for (int k = 1; k < NSEG; k++) begin
      src_v[k]   = vld_q[k-1];
      src_a[k]   = a_q[k-1];
      src_b[k]   = b_q[k-1];
      src_res[k] = res_q[k-1];
      src_c[k]   = c_q[k-1];
    end
  end

  // Both carry hypotheses are summed, then the incoming carry picks one.
  always_comb begin
    logic [BLOCK:0] s0;
    logic [BLOCK:0] s1;
    logic [BLOCK:0] pick;
    for (int k = 0; k < NSEG; k++) begin
      s0 = {1'b0, src_a[k][k*BLOCK +: BLOCK]} + {1'b0, src_b[k][k*BLOCK +: BLOCK]};
      s1 = {1'b0, src_a[k][k*BLOCK +: BLOCK]} + {1'b0, src_b[k][k*BLOCK +: BLOCK]} + (BLOCK+1)'(1);
      pick = src_c[k] ? s1 : s0;
      nxt_res[k] = src_res[k];
      nxt_res[k][k*BLOCK +: BLOCK] = pick[BLOCK-1:0];
      nxt_c[k]  = pick[BLOCK];
      nxt_cm[k] = pick[BLOCK-1] ^ src_a[k][k*BLOCK+BLOCK-1] ^ src_b[k][k*BLOCK+BLOCK-1];
    end
  end

  // Readiness ripples backwards from out_ready, so a full pipe still moves one slot per cycle.
  always_comb begin
    logic down;
    load = '0;
    down = bus.out_ready;
    for (int k = NSEG - 1; k >= 0; k--) begin
      down    = ~vld_q[k] | down;
      load[k] = down;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      for (int k = 0; k < NSEG; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        res_q[k] <= '0;
        c_q[k]   <= 1'b0;
        cm_q[k]  <= 1'b0;
      end
    end else begin
      for (int k = 0; k < NSEG; k++) begin
        if (load[k]) begin
          vld_q[k] <= src_v[k];
          if (src_v[k]) begin
            a_q[k]   <= src_a[k];
            b_q[k]   <= src_b[k];
            res_q[k] <= nxt_res[k];
            c_q[k]   <= nxt_c[k];
            cm_q[k]  <= nxt_cm[k];
          end
        end
      end
    end
  end

  assign bus.in_ready  = load[0];
  assign bus.out_valid = vld_q[NSEG-1];
  assign bus.sum       = res_q[NSEG-1];
  assign bus.cout      = c_q[NSEG-1];
  assign bus.overflow  = cm_q[NSEG-1] ^ c_q[NSEG-1];
  assign bus.zero      = vld_q[NSEG-1] && (res_q[NSEG-1] == '0);
endmodule

// File: tb/tb_csa_pipe.sv
// tb_csa_pipe: scoreboard bench for csa_pipe at 32/16, with spot checks of the 64/16 and 8/8 configurations.
module tb_csa_pipe;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  csa_pipe_if #(.WIDTH(32)) bus32 ();
  csa_pipe_if #(.WIDTH(64)) bus64 ();
  csa_pipe_if #(.WIDTH(8))  bus8 ();

  csa_pipe #(.WIDTH(32), .BLOCK(16)) dut32 (.clock(clock), .reset(reset), .bus(bus32));
  csa_pipe #(.WIDTH(64), .BLOCK(16)) dut64 (.clock(clock), .reset(reset), .bus(bus64));
  csa_pipe #(.WIDTH(8),  .BLOCK(8))  dut8  (.clock(clock), .reset(reset), .bus(bus8));

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        cin;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    int          acc_cycle;
    bit          chk_lat;
  } exp_t;

  int    checks = 0;
  int    fails = 0;
  int    cycle = 0;
  int    popped = 0;
  int    w;
  int    lat;
  bit    saw_full = 1'b0;
  exp_t  sb_q [$];
  exp_t  exp_pending;
  exp_t  mon_e;
  vec_t  tbl [12];
  vec_t  stall_v [6];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_sum;
  logic        prev_cout, prev_ovf, prev_zero;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t model(input logic [31:0] a, input logic [31:0] b, input logic sub, input logic cin);
    vec_t        v;
    logic [31:0] bb;
    logic        c0;
    logic [32:0] full;
    logic [31:0] low;
    bb   = sub ? ~b : b;
    c0   = sub ? 1'b1 : cin;
    full = {1'b0, a} + {1'b0, bb} + {32'b0, c0};
    low  = {1'b0, a[30:0]} + {1'b0, bb[30:0]} + {31'b0, c0};
    v.a = a; v.b = b; v.sub = sub; v.cin = cin;
    v.sum  = full[31:0];
    v.cout = full[32];
    v.ovf  = low[31] ^ full[32];
    v.zero = (full[31:0] == 32'd0);
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v, input bit chk_lat, output int waits);
    waits = 0;
    bus32.a   = v.a;
    bus32.b   = v.b;
    bus32.sub = v.sub;
    bus32.cin = v.cin;
    exp_pending.sum     = v.sum;
    exp_pending.cout    = v.cout;
    exp_pending.ovf     = v.ovf;
    exp_pending.zero    = v.zero;
    exp_pending.chk_lat = chk_lat;
    bus32.in_valid = 1'b1;
    forever begin
      @(negedge clock);
      if (bus32.in_ready) break;
      waits++;
      if (waits >= 100) begin
        checks++;
        fails++;
        $display("[TB] FAIL accept_timeout: got in_ready 0 for %0d cycles, expected 1", waits);
        break;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while ((sb_q.size() != 0 || bus32.out_valid) && n < 50) begin
      @(negedge clock);
      n++;
    end
    checkOutput(name, 64'(sb_q.size()), 64'd0);
    @(posedge clock);
    #1;
  endtask

  // Scoreboard: pushes on input transfer, pops and compares on output transfer, watches holds during stalls.
  always @(negedge clock) begin
    cycle++;
    if (!reset) begin
      sb_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checkOutput("hold_valid", 64'(bus32.out_valid), 64'd1);
        checkOutput("hold_sum", 64'(bus32.sum), 64'(prev_sum));
        checkOutput("hold_cout", 64'(bus32.cout), 64'(prev_cout));
        checkOutput("hold_overflow", 64'(bus32.overflow), 64'(prev_ovf));
        checkOutput("hold_zero", 64'(bus32.zero), 64'(prev_zero));
      end
      if (bus32.out_valid && bus32.out_ready) begin
        checkOutput("result_expected", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
          mon_e = sb_q.pop_front();
          popped++;
          checkOutput("sum", 64'(bus32.sum), 64'(mon_e.sum));
          checkOutput("cout", 64'(bus32.cout), 64'(mon_e.cout));
          checkOutput("overflow", 64'(bus32.overflow), 64'(mon_e.ovf));
          checkOutput("zero", 64'(bus32.zero), 64'(mon_e.zero));
          if (mon_e.chk_lat) checkOutput("latency", 64'(cycle - mon_e.acc_cycle), 64'd2);
        end
      end
      if (bus32.in_valid && bus32.in_ready) begin
        mon_e = exp_pending;
        mon_e.acc_cycle = cycle;
        sb_q.push_back(mon_e);
      end
      if (bus32.in_valid && !bus32.in_ready) saw_full = 1'b1;
      prev_stall = bus32.out_valid && !bus32.out_ready;
      prev_sum   = bus32.sum;
      prev_cout  = bus32.cout;
      prev_ovf   = bus32.overflow;
      prev_zero  = bus32.zero;
    end
  end

  initial begin
    tbl[0]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    tbl[3]  = '{32'h0000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{32'h1234_5678, 32'h0000_FFFF, 1'b0, 1'b1, 32'h1235_5678, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{32'h0000_0005, 32'h0000_0005, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
    tbl[8]  = '{32'h0000_8000, 32'h0000_8000, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{32'h0000_0003, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{32'h0000_0010, 32'h0000_0003, 1'b1, 1'b0, 32'h0000_000D, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++)
      stall_v[i] = model(32'h0000_FFFF + 32'(i) * 32'h0100_0000, 32'(i + 1), 1'(i % 2), 1'b1);

    reset = 1'b0;
    bus32.in_valid = 1'b0; bus32.a = '0; bus32.b = '0; bus32.sub = 1'b0; bus32.cin = 1'b0; bus32.out_ready = 1'b1;
    bus64.in_valid = 1'b0; bus64.a = '0; bus64.b = '0; bus64.sub = 1'b0; bus64.cin = 1'b0; bus64.out_ready = 1'b1;
    bus8.in_valid  = 1'b0; bus8.a  = '0; bus8.b  = '0; bus8.sub  = 1'b0; bus8.cin  = 1'b0; bus8.out_ready  = 1'b1;

    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("reset_out_valid", 64'(bus32.out_valid), 64'd0);
    checkOutput("reset_sum", 64'(bus32.sum), 64'd0);
    checkOutput("reset_cout", 64'(bus32.cout), 64'd0);
    checkOutput("reset_overflow", 64'(bus32.overflow), 64'd0);
    checkOutput("reset_zero", 64'(bus32.zero), 64'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    checkOutput("release_in_ready", 64'(bus32.in_ready), 64'd1);
    checkOutput("release_zero", 64'(bus32.zero), 64'd0);
    @(posedge clock);
    #1;

    $display("[TB] isolated vectors");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(tbl[i], 1'b1, w);
      bus32.in_valid = 1'b0;
      waitDrain("single_drain");
    end

    $display("[TB] back-to-back vectors");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(tbl[i], 1'b1, w);
      checkOutput("burst_no_wait", 64'(w), 64'd0);
    end
    bus32.in_valid = 1'b0;
    waitDrain("burst_drain");

    $display("[TB] back-pressure");
    popped = 0;
    saw_full = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) applyStimulus(stall_v[i], 1'b0, w);
        bus32.in_valid = 1'b0;
      end
      begin
        repeat (2) @(posedge clock);
        #1 bus32.out_ready = 1'b0;
        repeat (5) @(posedge clock);
        #1 bus32.out_ready = 1'b1;
      end
    join
    waitDrain("stall_drain");
    checkOutput("stall_backpressure", 64'(saw_full), 64'd1);
    checkOutput("stall_count", 64'(popped), 64'd6);

    $display("[TB] reset mid-flight");
    applyStimulus(model(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0), 1'b0, w);
    applyStimulus(model(32'hAAAA_0000, 32'h0000_FFFF, 1'b1, 1'b0), 1'b0, w);
    bus32.in_valid = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    checkOutput("midrst_out_valid", 64'(bus32.out_valid), 64'd0);
    checkOutput("midrst_sum", 64'(bus32.sum), 64'd0);
    checkOutput("midrst_zero", 64'(bus32.zero), 64'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    checkOutput("midrst_in_ready", 64'(bus32.in_ready), 64'd1);
    checkOutput("midrst_zero_idle", 64'(bus32.zero), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checkOutput("midrst_no_result", 64'(bus32.out_valid), 64'd0);
    end
    @(posedge clock);
    #1;

    $display("[TB] WIDTH=64 BLOCK=16");
    bus64.a = 64'h0000_0000_FFFF_FFFF;
    bus64.b = 64'd1;
    bus64.in_valid = 1'b1;
    @(negedge clock);
    checkOutput("w64_accept", 64'(bus64.in_ready), 64'd1);
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
      bus64.in_valid = 1'b0;
    end while (!bus64.out_valid && lat < 20);
    checkOutput("w64_latency", 64'(lat), 64'd4);
    checkOutput("w64_sum", bus64.sum, 64'h0000_0001_0000_0000);
    checkOutput("w64_cout", 64'(bus64.cout), 64'd0);
    checkOutput("w64_overflow", 64'(bus64.overflow), 64'd0);

    $display("[TB] WIDTH=8 BLOCK=8");
    @(posedge clock);
    #1;
    bus8.a = 8'h7F;
    bus8.b = 8'h01;
    bus8.in_valid = 1'b1;
    @(negedge clock);
    checkOutput("w8_accept", 64'(bus8.in_ready), 64'd1);
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
      bus8.in_valid = 1'b0;
    end while (!bus8.out_valid && lat < 20);
    checkOutput("w8_latency", 64'(lat), 64'd1);
    checkOutput("w8_sum", 64'(bus8.sum), 64'h80);
    checkOutput("w8_overflow", 64'(bus8.overflow), 64'd1);
    checkOutput("w8_cout", 64'(bus8.cout), 64'd0);

    repeat (3) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/csa_pipe.md
Name: csa_pipe

Overview:
- Parametrised, pipelined carry-select adder/subtractor. It generalises the fixed 32-bit, two-segment combinational carry-select adder to WIDTH bits split into BLOCK-bit segments.
- Each segment occupies one pipeline stage. Within a stage, the sum is computed for both carry hypotheses and a mux selects the correct one using the registered carry from the stage before.
- Adds an add/subtract mode, carry-out, a correct signed-overflow flag and valid/ready flow control.
- Sits between the ALU operand muxes and the writeback register in the processor datapath.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of BLOCK.
BLOCK, 16, segment width in bits; NSEG = WIDTH/BLOCK = pipeline depth (>=1).

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
in_valid  input  1  operands present
in_ready  output  1  block accepts operands this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
sub  input  1  0 = A+B+cin, 1 = A-B (B inverted, cin ignored, carry-in forced to 1)
cin  input  1  carry-in for add
out_valid  output  1  result present
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result
cout  output  1  carry out of MSB (for sub: 1 = no borrow)
overflow  output  1  signed two's-complement overflow
zero  output  1  sum == 0

Behaviour:
- Transfer rules: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Stage k (k = 0..NSEG-1) holds:
  - a valid bit;
  - result bits [(k+1)*BLOCK-1:0];
  - carry into segment k+1;
  - carry into the MSB (meaningful only in the last stage);
  - unconsumed upper operand bits, with B already inverted if sub.
- Stage 0 computes segment 0 from the input operands and the effective carry-in. Carry-in = sub ? 1 : cin.
- Stage k>0 computes segment k twice (carry 0 and carry 1) from its held operand bits. It selects using the registered carry from stage k-1, then registers the result.
- Latency: out_valid asserts exactly NSEG cycles after an input transfer with no stall. NSEG = 1 degenerates to a registered single-segment adder.
- Throughput: one operation per cycle when out_ready is held high.
- Flow control: stage k loads when it is empty or its contents advance this cycle. in_ready = stage 0 empty or stage 0 advancing. Stall back-pressure ripples combinationally from out_ready to in_ready; there are no bubbles under sustained stall.
- Ordering: results are strictly in issue order. No result is dropped or duplicated while out_ready is low.
- Flags:
  - overflow = carry into MSB XOR cout, for both add and sub.
  - zero is computed from the final registered sum, combinationally at the output.
  - All flags are aligned with sum.
- Outputs are driven from the last stage registers. sum, cout, overflow and zero are held stable while out_valid && !out_ready.
- Reset (async assert, sync release): all valid bits clear; sum = 0, cout = 0, overflow = 0, zero = 0 (flag forced low while !out_valid); out_valid = 0. in_ready = 1 on the first cycle after release.
- Reset mid-operation: all in-flight results are discarded, with no partial output after release.
- Simultaneous events:
  - A full pipeline with out_ready high accepts a new input in the same cycle the oldest result leaves.
  - in_valid while in_ready is low: the operands are ignored and the producer must hold them.
- Illegal configuration: WIDTH % BLOCK != 0 fails elaboration via a generate-time check.

Test Plan:
- Add overflow (WIDTH=32, BLOCK=16): a=0x7FFFFFFF, b=0x00000001, sub=0, cin=0. Expect sum=0x80000000, overflow=1, cout=0, zero=0, out_valid 2 cycles after accept.
- Cross-segment carry: a=0x0000FFFF, b=0x00000001. Expect sum=0x00010000, cout=0, overflow=0. Also a=0xFFFFFFFF, b=0x00000001. Expect sum=0, cout=1, zero=1, overflow=0.
- Subtract:
  - 0x00000000-0x00000001 (cin=1 driven, ignored): sum=0xFFFFFFFF, cout=0, overflow=0.
  - 0x80000000-0x00000001: sum=0x7FFFFFFF, overflow=1, cout=1.
- Back-pressure: 6 back-to-back ops; out_ready low from cycle 2 for 5 cycles. Expect in_ready low once both stages are full, outputs stable during the stall, all 6 results in order after release, none lost.
- Reset mid-flight: 2 ops accepted, reset pulsed low for 1 cycle before either completes. Expect out_valid=0 and sum=0 immediately; no result emerges; in_ready=1 after release.
- Parameter sweep WIDTH=64, BLOCK=16: a=0x00000000FFFFFFFF, b=1. Expect sum=0x0000000100000000 with latency 4. Also cover WIDTH=8, BLOCK=8: latency 1.
